// File: rtl/multicycle_controller.sv
// multicycle_controller
// ----------------------------------------------------------------------------
// Moore-style sequencer for an RV32I-subset multicycle datapath. Walks each
// instruction through fetch, decode, address generation, memory access,
// execute and writeback. It drives the immediate select, the ALU operand
// muxes, the ALU function and the write strobes. Memory states wait on a
// ready handshake with an optional timeout. Unsupported instructions and
// memory timeouts park the FSM in TRAP and raise sticky flags.
//
// State table:
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   FETCH     | read instr at PC; on mem_ready load IR/OldPC and PC <= PC+4
//   DECODE    | ALUOut <= OldPC + imm (branch/jal target), pick instr class
//   MEMADR    | ALUOut <= rs1 + imm (load/store address)
//   MEMREAD   | read data at ALUOut, wait for mem_ready
//   MEMWB     | rd <= Data register
//   MEMWRITE  | write rs2 to ALUOut, wait for mem_ready
//   EXECR     | ALUOut <= rs1 op rs2
//   EXECI     | ALUOut <= rs1 op imm
//   ALUWB     | rd <= ALUOut
//   BRANCH    | compare rs1 - rs2, PC <= ALUOut when taken
//   JAL       | PC <= ALUOut (target), ALUOut <= OldPC + 4
//   LUI       | ALUOut <= 0 + U-immediate
//   TRAP      | dead end until reset; all strobes low
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   opcode/funct3/funct7b5 instruction fields from IR
//   zero                   ALU zero flag (branch compare)
//   mem_ready              memory handshake
//   mem_read, mem_write    memory requests
//   adr_src                memory address select (PC / ALUOut)
//   ir_write, pc_write     IR/OldPC and PC load strobes
//   reg_write              register file write enable
//   imm_src                immediate format select
//   alu_src_a, alu_src_b   ALU operand selects
//   alu_control            ALU function
//   result_src             result bus select
//   illegal, mem_fault     sticky fault flags
//   state_out              current state encoding
// ----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [2:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic       mem_fault,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10,
        ST_LUI      = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Counter only has to reach MEM_TIMEOUT-1; expiry is taken on the cycle
    // the count would reach MEM_TIMEOUT so a late mem_ready can still win.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          illegal_q, mem_fault_q;
    logic          illegal_set, fault_set;
    logic          wait_state, expire;
    logic          rtype_f3_ok;
    logic [2:0]    imm_by_op;
    logic [2:0]    alu_exec;

    logic       mem_read_c, mem_write_c, adr_src_c;
    logic       ir_write_c, pc_write_c, reg_write_c;
    logic [2:0] imm_src_c, alu_control_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;

    assign wait_state  = (state_q == ST_FETCH) || (state_q == ST_MEMREAD) ||
                         (state_q == ST_MEMWRITE);
    assign expire      = (MEM_TIMEOUT != 0) && wait_state && !mem_ready &&
                         (cnt_q == CNT_LAST);
    assign rtype_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                         (funct3 == 3'b110) || (funct3 == 3'b111);

    always_comb begin
        imm_by_op = IMM_I;
        case (opcode)
            OP_STORE:  imm_by_op = IMM_S;
            OP_BRANCH: imm_by_op = IMM_B;
            OP_JAL:    imm_by_op = IMM_J;
            OP_LUI:    imm_by_op = IMM_U;
            default:   imm_by_op = IMM_I;
        endcase
    end

    // sub only exists for register-register add; addi with instr[30] set is
    // still an add because bit 30 is part of the immediate there.
    always_comb begin
        alu_exec = ALU_ADD;
        case (funct3)
            3'b000:  alu_exec = ((state_q == ST_EXECR) && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_exec = ALU_SLT;
            3'b110:  alu_exec = ALU_OR;
            3'b111:  alu_exec = ALU_AND;
            default: alu_exec = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state_d != state_q) || mem_ready || (MEM_TIMEOUT == 0)) begin
            cnt_q <= '0;
        end else if (wait_state) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q   <= 1'b0;
            mem_fault_q <= 1'b0;
        end else begin
            if (illegal_set) illegal_q   <= 1'b1;
            if (fault_set)   mem_fault_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_set = 1'b0;
        fault_set   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (expire) begin
                    state_d   = ST_TRAP;
                    fault_set = 1'b1;
                end
            end
            ST_DECODE: begin
                state_d     = ST_TRAP;
                illegal_set = 1'b1;
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        if (funct3 == 3'b010) begin
                            state_d     = ST_MEMADR;
                            illegal_set = 1'b0;
                        end
                    end
                    OP_RTYPE: begin
                        if (rtype_f3_ok) begin
                            state_d     = ST_EXECR;
                            illegal_set = 1'b0;
                        end
                    end
                    OP_ITYPE: begin
                        if (rtype_f3_ok) begin
                            state_d     = ST_EXECI;
                            illegal_set = 1'b0;
                        end
                    end
                    OP_BRANCH: begin
                        if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
                            state_d     = ST_BRANCH;
                            illegal_set = 1'b0;
                        end
                    end
                    OP_JAL: begin
                        state_d     = ST_JAL;
                        illegal_set = 1'b0;
                    end
                    OP_LUI: begin
                        state_d     = ST_LUI;
                        illegal_set = 1'b0;
                    end
                    default: begin
                        state_d     = ST_TRAP;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            ST_MEMADR:   state_d = (opcode == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD, ST_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = (state_q == ST_MEMREAD) ? ST_MEMWB : ST_FETCH;
                end else if (expire) begin
                    state_d   = ST_TRAP;
                    fault_set = 1'b1;
                end
            end
            ST_MEMWB:    state_d = ST_FETCH;
            ST_EXECR:    state_d = ST_ALUWB;
            ST_EXECI:    state_d = ST_ALUWB;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JAL:      state_d = ST_ALUWB;
            ST_LUI:      state_d = ST_ALUWB;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        adr_src_c     = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        imm_src_c     = IMM_I;
        alu_src_a_c   = SRCA_PC;
        alu_src_b_c   = SRCB_RS2;
        alu_control_c = ALU_ADD;
        result_src_c  = RES_ALUOUT;
        case (state_q)
            ST_FETCH: begin
                mem_read_c   = 1'b1;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURES;
                ir_write_c   = mem_ready;
                pc_write_c   = mem_ready;
            end
            ST_DECODE: begin
                imm_src_c   = imm_by_op;
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
            end
            ST_MEMADR: begin
                imm_src_c   = imm_by_op;
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
            end
            ST_MEMREAD: begin
                adr_src_c  = 1'b1;
                mem_read_c = 1'b1;
            end
            ST_MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
            end
            ST_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
            end
            ST_EXECR: begin
                alu_src_a_c   = SRCA_RS1;
                alu_src_b_c   = SRCB_RS2;
                alu_control_c = alu_exec;
            end
            ST_EXECI: begin
                alu_src_a_c   = SRCA_RS1;
                alu_src_b_c   = SRCB_IMM;
                alu_control_c = alu_exec;
            end
            ST_ALUWB: begin
                result_src_c = RES_ALUOUT;
                reg_write_c  = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_c   = SRCA_RS1;
                alu_src_b_c   = SRCB_RS2;
                alu_control_c = ALU_SUB;
                pc_write_c    = (funct3 == 3'b000) ? zero : ~zero;
            end
            ST_JAL: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_FOUR;
                pc_write_c  = 1'b1;
            end
            ST_LUI: begin
                imm_src_c   = IMM_U;
                alu_src_a_c = SRCA_ZERO;
                alu_src_b_c = SRCB_IMM;
            end
            default: begin
                mem_read_c = 1'b0;
            end
        endcase
    end

    // Reset gates every output so FETCH's read request and selects never
    // reach the datapath while rst_n is held low.
    assign mem_read    = rst_n & mem_read_c;
    assign mem_write   = rst_n & mem_write_c;
    assign adr_src     = rst_n & adr_src_c;
    assign ir_write    = rst_n & ir_write_c;
    assign pc_write    = rst_n & pc_write_c;
    assign reg_write   = rst_n & reg_write_c;
    assign imm_src     = rst_n ? imm_src_c     : 3'b000;
    assign alu_src_a   = rst_n ? alu_src_a_c   : 2'b00;
    assign alu_src_b   = rst_n ? alu_src_b_c   : 2'b00;
    assign alu_control = rst_n ? alu_control_c : 3'b000;
    assign result_src  = rst_n ? result_src_c  : 2'b00;
    assign illegal     = illegal_q;
    assign mem_fault   = mem_fault_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [2:0] imm_src, alu_control;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic       illegal, mem_fault;
    logic [3:0] state_out;

    multicycle_controller #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .result_src(result_src),
        .illegal(illegal), .mem_fault(mem_fault), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // strb = {mem_read, mem_write, ir_write, pc_write, reg_write}
    // sel  = {adr_src, alu_src_a, alu_src_b}, flt = {illegal, mem_fault}
    typedef struct packed {
        logic [3:0] st;
        logic [4:0] strb;
        logic [2:0] imm;
        logic [2:0] alu;
        logic [1:0] rs;
        logic [4:0] sel;
        logic [1:0] flt;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    string cur_tag = "init";
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] st, input logic [4:0] strb,
                                input logic [2:0] imm, input logic [2:0] alu,
                                input logic [1:0] rs, input logic [4:0] sel,
                                input logic [1:0] flt);
        exp_t e;
        e.st = st; e.strb = strb; e.imm = imm; e.alu = alu;
        e.rs = rs; e.sel = sel; e.flt = flt;
        return e;
    endfunction

    // Scoreboard side: compare each expected cycle at the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            string t;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check_val({t, ".st"},   32'(state_out), 32'(e.st));
            check_val({t, ".strb"}, 32'({mem_read, mem_write, ir_write, pc_write, reg_write}), 32'(e.strb));
            check_val({t, ".imm"},  32'(imm_src), 32'(e.imm));
            check_val({t, ".alu"},  32'(alu_control), 32'(e.alu));
            check_val({t, ".rs"},   32'(result_src), 32'(e.rs));
            check_val({t, ".sel"},  32'({adr_src, alu_src_a, alu_src_b}), 32'(e.sel));
            check_val({t, ".flt"},  32'({illegal, mem_fault}), 32'(e.flt));
        end
    end

    int step_no = 0;

    task automatic step(input logic rdy, input logic zr, input exp_t e);
        mem_ready = rdy;
        zero = zr;
        sb_q.push_back(e);
        tag_q.push_back($sformatf("%s#%0d", cur_tag, step_no));
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input string name, input logic [6:0] op, input logic [2:0] f3, input logic f7);
        cur_tag = name;
        step_no = 0;
        opcode = op;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        check_val({name, ".rst_st"},   32'(state_out), 32'd0);
        check_val({name, ".rst_strb"}, 32'({mem_read, mem_write, ir_write, pc_write, reg_write}), 32'd0);
        check_val({name, ".rst_sel"},  32'({imm_src, alu_control, result_src, adr_src, alu_src_a, alu_src_b}), 32'd0);
        check_val({name, ".rst_flt"},  32'({illegal, mem_fault}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fetch_ok();
        step(1'b1, 1'b0, mk(4'd0, 5'b10110, 3'b000, 3'b000, 2'b10, 5'b00010, 2'b00));
    endtask

    task automatic aluwb();
        step(1'b1, 1'b0, mk(4'd8, 5'b00001, 3'b000, 3'b000, 2'b00, 5'b00000, 2'b00));
    endtask

    typedef struct packed {
        logic       itype;
        logic [2:0] f3;
        logic       f7;
        logic [2:0] alu;
    } alu_case_t;

    alu_case_t alu_tab[7];

    initial begin
        alu_tab[0] = '{1'b0, 3'b000, 1'b1, 3'b001};
        alu_tab[1] = '{1'b0, 3'b000, 1'b0, 3'b000};
        alu_tab[2] = '{1'b0, 3'b010, 1'b0, 3'b101};
        alu_tab[3] = '{1'b0, 3'b110, 1'b0, 3'b011};
        alu_tab[4] = '{1'b0, 3'b111, 1'b0, 3'b010};
        alu_tab[5] = '{1'b1, 3'b000, 1'b1, 3'b000};
        alu_tab[6] = '{1'b1, 3'b010, 1'b0, 3'b101};

        #2;
        do_reset("por");

        // sw x5,8(x2): three wait cycles in MEMWRITE
        set_ir("sw", 7'b0100011, 3'b010, 1'b0);
        fetch_ok();
        step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b001, 3'b000, 2'b00, 5'b00101, 2'b00));
        step(1'b1, 1'b0, mk(4'd2, 5'b00000, 3'b001, 3'b000, 2'b00, 5'b01001, 2'b00));
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, mk(4'd5, 5'b01000, 3'b000, 3'b000, 2'b00, 5'b10000, 2'b00));
        step(1'b1, 1'b0, mk(4'd5, 5'b01000, 3'b000, 3'b000, 2'b00, 5'b10000, 2'b00));

        // lw with memory always ready
        set_ir("lw", 7'b0000011, 3'b010, 1'b0);
        fetch_ok();
        step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b000, 3'b000, 2'b00, 5'b00101, 2'b00));
        step(1'b1, 1'b0, mk(4'd2, 5'b00000, 3'b000, 3'b000, 2'b00, 5'b01001, 2'b00));
        step(1'b1, 1'b0, mk(4'd3, 5'b10000, 3'b000, 3'b000, 2'b00, 5'b10000, 2'b00));
        step(1'b1, 1'b0, mk(4'd4, 5'b00001, 3'b000, 3'b000, 2'b01, 5'b00000, 2'b00));

        // branches: beq/zero=1 taken, bne/zero=1 not taken, bne/zero=0 taken
        set_ir("beq_z1", 7'b1100011, 3'b000, 1'b0);
        fetch_ok();
        step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b010, 3'b000, 2'b00, 5'b00101, 2'b00));
        step(1'b1, 1'b1, mk(4'd9, 5'b00010, 3'b000, 3'b001, 2'b00, 5'b01000, 2'b00));
        set_ir("bne_z1", 7'b1100011, 3'b001, 1'b0);
        fetch_ok();
        step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b010, 3'b000, 2'b00, 5'b00101, 2'b00));
        step(1'b1, 1'b1, mk(4'd9, 5'b00000, 3'b000, 3'b001, 2'b00, 5'b01000, 2'b00));
        set_ir("bne_z0", 7'b1100011, 3'b001, 1'b0);
        fetch_ok();
        step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b010, 3'b000, 2'b00, 5'b00101, 2'b00));
        step(1'b1, 1'b0, mk(4'd9, 5'b00010, 3'b000, 3'b001, 2'b00, 5'b01000, 2'b00));

        // R/I-type ALU function decode
        for (int k = 0; k < 7; k++) begin
            set_ir($sformatf("alu%0d", k), alu_tab[k].itype ? 7'b0010011 : 7'b0110011,
                   alu_tab[k].f3, alu_tab[k].f7);
            fetch_ok();
            step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b000, 3'b000, 2'b00, 5'b00101, 2'b00));
            if (alu_tab[k].itype)
                step(1'b1, 1'b0, mk(4'd7, 5'b00000, 3'b000, alu_tab[k].alu, 2'b00, 5'b01001, 2'b00));
            else
                step(1'b1, 1'b0, mk(4'd6, 5'b00000, 3'b000, alu_tab[k].alu, 2'b00, 5'b01000, 2'b00));
            aluwb();
        end

        // jal and lui
        set_ir("jal", 7'b1101111, 3'b000, 1'b0);
        fetch_ok();
        step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b011, 3'b000, 2'b00, 5'b00101, 2'b00));
        step(1'b1, 1'b0, mk(4'd10, 5'b00010, 3'b000, 3'b000, 2'b00, 5'b00110, 2'b00));
        aluwb();
        set_ir("lui", 7'b0110111, 3'b000, 1'b0);
        fetch_ok();
        step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b100, 3'b000, 2'b00, 5'b00101, 2'b00));
        step(1'b1, 1'b0, mk(4'd11, 5'b00000, 3'b100, 3'b000, 2'b00, 5'b01101, 2'b00));
        aluwb();

        // lw where mem_ready arrives on the cycle the timeout would expire
        set_ir("lw_late", 7'b0000011, 3'b010, 1'b0);
        fetch_ok();
        step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b000, 3'b000, 2'b00, 5'b00101, 2'b00));
        step(1'b1, 1'b0, mk(4'd2, 5'b00000, 3'b000, 3'b000, 2'b00, 5'b01001, 2'b00));
        for (int i = 0; i < 14; i++)
            step(1'b0, 1'b0, mk(4'd3, 5'b10000, 3'b000, 3'b000, 2'b00, 5'b10000, 2'b00));
        step(1'b1, 1'b0, mk(4'd3, 5'b10000, 3'b000, 3'b000, 2'b00, 5'b10000, 2'b00));
        step(1'b1, 1'b0, mk(4'd4, 5'b00001, 3'b000, 3'b000, 2'b01, 5'b00000, 2'b00));

        // illegal opcode
        set_ir("ill_op", 7'b0000000, 3'b000, 1'b0);
        fetch_ok();
        step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b000, 3'b000, 2'b00, 5'b00101, 2'b00));
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, mk(4'd12, 5'b00000, 3'b000, 3'b000, 2'b00, 5'b00000, 2'b10));
        do_reset("ill_op_rst");

        // unsupported R-type funct3
        set_ir("ill_f3", 7'b0110011, 3'b001, 1'b0);
        fetch_ok();
        step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b000, 3'b000, 2'b00, 5'b00101, 2'b00));
        step(1'b1, 1'b0, mk(4'd12, 5'b00000, 3'b000, 3'b000, 2'b00, 5'b00000, 2'b10));
        do_reset("ill_f3_rst");

        // FETCH timeout: 15 waiting cycles then TRAP with mem_fault
        set_ir("tmo", 7'b0000011, 3'b010, 1'b0);
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b0, mk(4'd0, 5'b10000, 3'b000, 3'b000, 2'b10, 5'b00010, 2'b00));
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b0, mk(4'd12, 5'b00000, 3'b000, 3'b000, 2'b00, 5'b00000, 2'b01));
        do_reset("tmo_rst");

        // reset asserted in the middle of MEMWRITE
        set_ir("sw_rst", 7'b0100011, 3'b010, 1'b0);
        fetch_ok();
        step(1'b1, 1'b0, mk(4'd1, 5'b00000, 3'b001, 3'b000, 2'b00, 5'b00101, 2'b00));
        step(1'b1, 1'b0, mk(4'd2, 5'b00000, 3'b001, 3'b000, 2'b00, 5'b01001, 2'b00));
        step(1'b0, 1'b0, mk(4'd5, 5'b01000, 3'b000, 3'b000, 2'b00, 5'b10000, 2'b00));
        mem_ready = 1'b0;
        #1;
        check_val("sw_rst.pre_mw", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("sw_rst.mw_drop", 32'(mem_write), 32'd0);
        check_val("sw_rst.st_drop", 32'(state_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ir("after_rst", 7'b0110111, 3'b000, 1'b0);
        fetch_ok();

        @(negedge clk);
        #1;
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences the RV32I subset multicycle datapath: fetch, decode, address generation, memory access, execute, writeback.
- Drives the immediate-extender select (including S-type), ALU operand muxes, ALU function, and register/memory/PC/IR write strobes.
- Adds a memory ready handshake with timeout, and sticky fault reporting for illegal instructions.

Parameters:
- MEM_TIMEOUT, 15, consecutive cycles a memory state may wait with mem_ready low before faulting; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instr[6:0] from IR
- funct3  input  3  instr[14:12] from IR
- funct7b5  input  1  instr[30] from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory accepted write / read data valid this cycle
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- adr_src  output  1  0 = PC, 1 = ALUOut as memory address
- ir_write  output  1  load IR and OldPC
- pc_write  output  1  load PC from result bus
- reg_write  output  1  register file write enable
- imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U
- alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 reg A, 11 zero
- alu_src_b  output  2  00 rs2 reg, 01 ImmExt, 10 constant 4
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- result_src  output  2  00 ALUOut, 01 Data reg, 10 ALUResult
- illegal  output  1  sticky: unsupported instruction decoded
- mem_fault  output  1  sticky: memory timeout
- state_out  output  4  current state encoding, for debug

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, TRAP 12.
- Reset (rst_n low, asynchronous):
  - state = FETCH, timeout counter = 0, illegal = mem_fault = 0.
  - All strobes (mem_read, mem_write, ir_write, pc_write, reg_write) forced 0 while rst_n is low.
  - All selects = 0.
- Defaults: any output not listed for a state is 0.
- FETCH:
  - mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=add, result_src=10.
  - When mem_ready=1: ir_write=1, pc_write=1 in that same cycle; next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - alu_src_a=01, alu_src_b=01, add (branch target into ALUOut).
  - imm_src by opcode: 0000011/0010011 → I, 0100011 → S, 1100011 → B, 1101111 → J, 0110111 → U.
  - Next state:
    - 0000011 or 0100011 with funct3=010 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 with funct3 000 or 001 → BRANCH.
    - 1101111 → JAL.
    - 0110111 → LUI.
    - Anything else → TRAP, and illegal is set.
  - R/I funct3 support: only 000, 010, 110, 111; any other value → TRAP, illegal set.
- MEMADR: alu_src_a=10, alu_src_b=01, add, imm_src held per opcode. Next state MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: adr_src=1, mem_read=1. Next state MEMWB on mem_ready; otherwise stay.
- MEMWB: result_src=01, reg_write=1. Next state FETCH.
- MEMWRITE: adr_src=1, mem_write=1, held until mem_ready. Next state FETCH on mem_ready.
- EXECR / EXECI:
  - alu_src_a=10; alu_src_b=00 in EXECR, 01 in EXECI.
  - alu_control by funct3: 000 → add, or sub only when EXECR and funct7b5=1; 010 → slt; 110 → or; 111 → and.
  - Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state FETCH.
- BRANCH:
  - alu_src_a=10, alu_src_b=00, sub, result_src=00.
  - pc_write = zero when funct3=000 (beq), ~zero when funct3=001 (bne).
  - Next state FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Next state ALUWB, which writes OldPC+4.
- LUI: alu_src_a=11, alu_src_b=01, imm_src=100, add. Next state ALUWB.
- Timeout counter (FETCH, MEMREAD, MEMWRITE only):
  - Cleared on entry to each of these states and whenever mem_ready=1.
  - Increments each cycle mem_ready=0.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT: next state TRAP, mem_fault set, and mem_read/mem_write drop.
- TRAP: all strobes 0. Stays in TRAP until reset; illegal and mem_fault hold until reset.
- Simultaneous events: mem_ready on the same cycle the counter would expire → mem_ready wins; normal transition.
- Latencies with mem_ready always 1:
  - Load: 5 cycles.
  - Store, R, I, LUI, JAL: 4 cycles.
  - Branch: 3 cycles.

Test Plan:
- sw x5,8(x2) = 0x00512423, mem_ready low 3 cycles in MEMWRITE → state_out 0,1,2,5,5,5,5,0; imm_src=001 in DECODE/MEMADR; mem_write=1 for exactly 4 cycles; reg_write never asserted.
- lw, mem_ready=1 always → 5 cycles; ir_write only in FETCH; reg_write=1 with result_src=01 only in MEMWB.
- beq with zero=1 → pc_write=1 in BRANCH. bne with zero=1 → pc_write=0. Both return to FETCH.
- R-type funct3=000 funct7b5=1 → alu_control=001 in EXECR. Same with I-type opcode → 000. funct3=010 → 101. reg_write in ALUWB only.
- opcode 0000000 → TRAP on cycle 3, illegal=1 until reset. FETCH with mem_ready stuck low, MEM_TIMEOUT=15 → TRAP after 15 waiting cycles, mem_fault=1.
- Assert rst_n low mid-MEMWRITE → mem_write drops combinationally; after release state_out=0; fault flags cleared.
